// File: rtl/reset_req_pkg.sv
// Shared types and defaults for the pushbutton reset-request generator.
// The POR state value is always declared; it is only reachable when RESET_REQ_POR_EN is defined.
package reset_req_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      ASSERT   = 3'd2,
      WAIT_REL = 3'd3,
      REL_DB   = 3'd4,
      POR      = 3'd5
   } state_t;

   localparam int DEF_DB_TICKS      = 500000;
   localparam int DEF_STRETCH_TICKS = 16;
   localparam int DEF_POR_TICKS     = 1024;

   // Width that holds the largest tick value, plus one bit of headroom.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/reset_request_gen_sync2.sv
// Two-flop synchronizer with synchronous active-high reset; reusable for any slow pin input.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_request_gen.sv
// Debounced, stretched reset request from a bouncing pushbutton.
// Optional macro RESET_REQ_POR_EN adds a power-on hold state entered on reset.
module reset_request_gen
   import reset_req_pkg::*;
#(
   parameter int DB_TICKS      = DEF_DB_TICKS,
   parameter int STRETCH_TICKS = DEF_STRETCH_TICKS,
   parameter int POR_TICKS     = DEF_POR_TICKS,
   parameter int CNT_W         = cnt_width(DB_TICKS, STRETCH_TICKS, POR_TICKS)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic rst_out,
   output logic rst_pulse,
   output logic busy
);

   localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DB_TICKS - 1);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_TICKS - 1);
`ifdef RESET_REQ_POR_EN
   localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_TICKS - 1);
`endif

   logic             btn_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rst_out_q, rst_out_d;
   logic             rst_pulse_q, rst_pulse_d;
   logic             busy_q, busy_d;

   sync2 u_sync2 (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (btn_s)
   );

   // State, counter and the registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef RESET_REQ_POR_EN
         state_q   <= POR;
         rst_out_q <= 1'b1;
         busy_q    <= 1'b1;
`else
         state_q   <= IDLE;
         rst_out_q <= 1'b0;
         busy_q    <= 1'b0;
`endif
         cnt_q       <= '0;
         rst_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rst_out_q   <= rst_out_d;
         rst_pulse_q <= rst_pulse_d;
         busy_q      <= busy_d;
      end
   end

   // Next state; btn_s is tested before the terminal count so a bounce always wins.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_DB;
               cnt_d   = '0;
            end
         end
         PRESS_DB: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ASSERT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ASSERT: begin
            if (cnt_q == STRETCH_LAST) begin
               state_d = WAIT_REL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_REL: begin
            if (!btn_s) begin
               state_d = REL_DB;
               cnt_d   = '0;
            end
         end
         REL_DB: begin
            if (btn_s) begin
               state_d = WAIT_REL;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef RESET_REQ_POR_EN
         POR: begin
            if (cnt_q == POR_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      rst_out_d   = (state_d != IDLE) && (state_d != PRESS_DB);
      busy_d      = (state_d != IDLE);
      rst_pulse_d = (state_d == ASSERT) && (state_q != ASSERT);
   end

   assign rst_out   = rst_out_q;
   assign rst_pulse = rst_pulse_q;
   assign busy      = busy_q;

endmodule
